forward_history_buffer: RTL

FORWARD_HISTORY_BUFFER -- requirements
Module: forward_history_buffer

---
 rtl/forward_pkg.sv | 37 +++
 rtl/forward_stage_reg.sv | 35 +++
 rtl/forward_history_buffer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/forward_pkg.sv
// Shared record types and helpers for the forward history buffer.
// Stage records use fixed maximum field widths; users slice down to their parameters.
package forward_pkg;

  localparam int FWD_DATA_MAX = 32;
  localparam int FWD_KEY_MAX  = 32;
  localparam int FWD_ADR_MAX  = 16;

  typedef struct packed {
    logic                    updated_mem;
    logic                    valid;
    logic [FWD_ADR_MAX-1:0]  adr;
    logic [FWD_KEY_MAX-1:0]  key;
    logic [FWD_DATA_MAX-1:0] data;
  } fwd_wr_entry_t;

  typedef struct packed {
    logic                   shift_valid;
    logic [FWD_ADR_MAX-1:0] shift_adr;
  } fwd_shift_entry_t;

  function automatic int fill_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Keeps only the low 'width' bits of a table address.
  function automatic logic [FWD_ADR_MAX-1:0] mask_adr(input logic [FWD_ADR_MAX-1:0] adr,
                                                      input int width);
    logic [FWD_ADR_MAX-1:0] mask;
    mask = '0;
    for (int b = 0; b < FWD_ADR_MAX; b++) begin
      if (b < width) mask[b] = 1'b1;
    end
    return adr & mask;
  endfunction

endpackage

// File: rtl/forward_stage_reg.sv
// One history stage: the write record of every table plus the shift record of
// every table boundary, advanced together on enabled edges.
module forward_stage_reg
  import forward_pkg::*;
#(
  parameter int NUMBER_OF_TABLES = 3
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       clk_en,
  input  logic                                       clear,
  input  fwd_wr_entry_t    [NUMBER_OF_TABLES-1:0]    wr_d,
  input  fwd_shift_entry_t [NUMBER_OF_TABLES-2:0]    shift_d,
  output fwd_wr_entry_t    [NUMBER_OF_TABLES-1:0]    wr_q,
  output fwd_shift_entry_t [NUMBER_OF_TABLES-2:0]    shift_q
);

  // NOTE: flops use non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the history chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      shift_q <= '0;
    end else if (clk_en) begin
      if (clear) begin
        wr_q    <= '0;
        shift_q <= '0;
      end else begin
        wr_q    <= wr_d;
        shift_q <= shift_d;
      end
    end
  end

endmodule

// File: rtl/forward_history_buffer.sv
// Forward history of cuckoo-table writes and inter-table shifts, stage 0 newest.
// Build option FORWARD_DEDUP_EN: clear updated_mem on older copies of a rewritten address.
module forward_history_buffer
  import forward_pkg::*;
#(
  parameter int DATA_WIDTH             = 4,
  parameter int KEY_WIDTH              = 2,
  parameter int NUMBER_OF_TABLES       = 3,
  parameter int FORWARDED_CLOCK_CYCLES = 2,
  parameter int MAX_HASH_ADR_WIDTH     = 2,
  parameter int HASH_TABLE_ADR_WIDTH [NUMBER_OF_TABLES] = '{2, 2, 2}
) (
  input  logic                                                                          clk,
  input  logic                                                                          reset,
  input  logic                                                                          clk_en,
  input  logic                                                                          flush_i,
  input  logic [NUMBER_OF_TABLES-1:0]                                                   wr_en_i,
  input  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]                           wr_hash_adr_i,
  input  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]                                   wr_data_i,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]                                    wr_key_i,
  input  logic [NUMBER_OF_TABLES-1:0]                                                   wr_valid_i,
  input  logic [NUMBER_OF_TABLES-2:0]                                                   shift_en_i,
  input  logic [NUMBER_OF_TABLES-2:0][MAX_HASH_ADR_WIDTH-1:0]                           shift_adr_i,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0] forward_hash_adr_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]       forward_data_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]        forward_key_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0]                       forward_valid_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0]                       forward_updated_mem_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-2:0][MAX_HASH_ADR_WIDTH-1:0] forward_shift_hash_adr_o,
  output logic [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-2:0]                       forward_shift_valid_o,
  output logic [fill_width(FORWARDED_CLOCK_CYCLES)-1:0]                                 fill_o
);

  localparam int T      = NUMBER_OF_TABLES;
  localparam int F      = FORWARDED_CLOCK_CYCLES;
  localparam int FILL_W = fill_width(FORWARDED_CLOCK_CYCLES);

  if (DATA_WIDTH > FWD_DATA_MAX || KEY_WIDTH > FWD_KEY_MAX ||
      MAX_HASH_ADR_WIDTH > FWD_ADR_MAX) begin : g_width_check
    $error("forward_history_buffer: field width exceeds forward_pkg record width");
  end

  fwd_wr_entry_t    [T-1:0]       wr_d    [F];
  fwd_wr_entry_t    [T-1:0]       wr_q    [F];
  fwd_shift_entry_t [T-2:0]       shift_d [F];
  fwd_shift_entry_t [T-2:0]       shift_q [F];
  logic [T-1:0][FWD_ADR_MAX-1:0]  in_adr;
  logic [T-2:0][FWD_ADR_MAX-1:0]  in_shift_adr;
  logic                           unused_bits;

  // Addresses are trimmed to each table's real depth before they are stored or compared.
  always_comb begin
    for (int i = 0; i < T; i++) begin
      in_adr[i] = mask_adr(FWD_ADR_MAX'(wr_hash_adr_i[i]), HASH_TABLE_ADR_WIDTH[i]);
    end
    for (int i = 0; i < T - 1; i++) begin
      in_shift_adr[i] = mask_adr(FWD_ADR_MAX'(shift_adr_i[i]), HASH_TABLE_ADR_WIDTH[i]);
    end
  end

  // NOTE: every field gets a default before the conditional updates, so no
  // path through this block leaves a variable unassigned and no latch appears.
  always_comb begin
    for (int k = 0; k < F; k++) begin
      wr_d[k]    = '0;
      shift_d[k] = '0;
    end

    for (int i = 0; i < T; i++) begin
      if (wr_en_i[i]) begin
        wr_d[0][i].updated_mem = 1'b1;
        wr_d[0][i].valid       = wr_valid_i[i];
        wr_d[0][i].adr         = in_adr[i];
        wr_d[0][i].key         = FWD_KEY_MAX'(wr_key_i[i]);
        wr_d[0][i].data        = FWD_DATA_MAX'(wr_data_i[i]);
      end
    end
    for (int i = 0; i < T - 1; i++) begin
      if (shift_en_i[i]) begin
        shift_d[0][i].shift_valid = 1'b1;
        shift_d[0][i].shift_adr   = in_shift_adr[i];
      end
    end

    for (int k = 1; k < F; k++) begin
      wr_d[k]    = wr_q[k-1];
      shift_d[k] = shift_q[k-1];
`ifdef FORWARD_DEDUP_EN
      for (int i = 0; i < T; i++) begin
        if (wr_en_i[i] && (wr_q[k-1][i].adr == in_adr[i])) begin
          wr_d[k][i].updated_mem = 1'b0;
        end
      end
`endif
    end
  end

  for (genvar k = 0; k < F; k++) begin : g_stage
    forward_stage_reg #(
      .NUMBER_OF_TABLES(T)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clk_en  (clk_en),
      .clear   ((k == 0) ? 1'b0 : flush_i),
      .wr_d    (wr_d[k]),
      .shift_d (shift_d[k]),
      .wr_q    (wr_q[k]),
      .shift_q (shift_q[k])
    );
  end

  // A flush edge still captures a fresh stage 0, hence the count restarts at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_o <= '0;
    end else if (clk_en) begin
      if (flush_i) begin
        fill_o <= FILL_W'(1);
      end else if (fill_o != FILL_W'(F)) begin
        fill_o <= fill_o + FILL_W'(1);
      end
    end
  end

  always_comb begin
    forward_hash_adr_o       = '0;
    forward_data_o           = '0;
    forward_key_o            = '0;
    forward_valid_o          = '0;
    forward_updated_mem_o    = '0;
    forward_shift_hash_adr_o = '0;
    forward_shift_valid_o    = '0;
    for (int k = 0; k < F; k++) begin
      for (int i = 0; i < T; i++) begin
        forward_updated_mem_o[k][i] = wr_q[k][i].updated_mem;
        forward_valid_o[k][i]       = wr_q[k][i].valid;
        forward_hash_adr_o[k][i]    = wr_q[k][i].adr[MAX_HASH_ADR_WIDTH-1:0];
        forward_key_o[k][i]         = wr_q[k][i].key[KEY_WIDTH-1:0];
        forward_data_o[k][i]        = wr_q[k][i].data[DATA_WIDTH-1:0];
      end
      for (int i = 0; i < T - 1; i++) begin
        forward_shift_valid_o[k][i]    = shift_q[k][i].shift_valid;
        forward_shift_hash_adr_o[k][i] = shift_q[k][i].shift_adr[MAX_HASH_ADR_WIDTH-1:0];
      end
    end
  end

  // Record bits above the configured widths are always zero and intentionally unread.
  always_comb begin
    unused_bits = 1'b0;
    for (int k = 0; k < F; k++) begin
      unused_bits = unused_bits ^ (^wr_q[k]) ^ (^shift_q[k]);
    end
  end

endmodule
